fetch_queue: RTL and testbench
==============================

// Module: fetch_queue
// PURPOSE
//  Parametrised successor to the PC/instr_ROM fetch path: prefetches instructions from a
//  registered-read ROM into an in-order queue. Presents {instr, instr_pc} to decode with a
//  valid/ready handshake. Accepts absolute redirects from the branch LUT/ALU with flush.
//  Raises a sticky done flag on retiring DONE_PC. Sits between instr_ROM and Control/reg_file.
// PARAMETERS
//  D        10   program counter width; PC wraps modulo 2**D
//  IW       9    instruction (machine code) width
//  DEPTH    4    queue entries, >=2
//  RESET_PC 0    fetch PC loaded on reset
//  DONE_PC  381  PC whose retirement asserts done
// PORTS
//  clk              in   1         clock; all state updates on posedge
//  reset            in   1         synchronous, active-high
//  rom_en           out  1         ROM read request this cycle
//  rom_addr         out  D         ROM read address (current fetch PC)
//  rom_data         in   IW        ROM data; valid the cycle after rom_en
//  redirect_en      in   1         taken branch/jump; flush and refetch
//  redirect_target  in   D         absolute new fetch PC
//  instr_valid      out  1         queue head valid
//  instr_ready      in   1         decode accepts head
//  instr            out  IW        head machine code
//  instr_pc         out  D         head PC
//  count            out  clog2(DEPTH+1)  queue occupancy
//  done             out  1         sticky; DONE_PC retired
// BEHAVIOUR
//  - One clock (clk); reset synchronous, active-high. Reset: fpc<=RESET_PC, queue empty,
//    inflight<=0, done<=0. Outputs: rom_en=0 in the reset cycle, instr_valid=0, count=0.
//    instr/instr_pc are don't-care while instr_valid=0.
//  - Reset mid-operation discards all queue and in-flight state. No partial retirement.
//  - Issue: rom_en = !reset & !done & !redirect_en & (count+inflight < DEPTH).
//    rom_addr=fpc. On issue, fpc<=fpc+1 mod 2**D and inflight<=1; otherwise inflight<=0.
//  - Fill: when inflight=1, {rom_data, pc of that request} is pushed at the end of that
//    cycle, unless redirect_en or done is high.
//  - Latency: issue in cycle N -> instr_valid for that entry in N+2 (no bypass).
//    With instr_ready held high: one instruction per cycle, sequential PCs.
//  - Head: instr_valid = (count != 0) & !done. Pop on instr_valid & instr_ready.
//    Entries retire strictly in push order.
//  - Simultaneous push and pop: count unchanged. Pop with count=0: impossible by
//    construction. Push when full: impossible, guarded by the issue rule.
//  - Redirect in cycle R (priority over pop, push, issue): queue cleared and count<=0 at
//    end of R. A pop in R is NOT retired: done is not set and decode must treat it as
//    squashed. No issue in R; fpc<=redirect_target.
//    Target issues in R+1 and is valid in R+3.
//  - Done: pop of an entry with instr_pc==DONE_PC sets done<=1 (visible next cycle, sticky
//    until reset). While done=1: rom_en=0, instr_valid=0, pushes dropped.
//  - Queue is a circular buffer with rd/wr pointers mod DEPTH. DEPTH need not be a power
//    of two; pointer wrap is explicit.
// TESTING
//  1 Release reset, ready=1: rom_addr 0,1,2.. from cycle 1; instr_valid from cycle 3;
//    instr_pc 0,1,2,3 back-to-back; instr matches ROM[pc].
//  2 ready=0 from reset: count climbs to 4 and holds; rom_en=0 once count+inflight=4.
//    Then ready=1: pcs 0..3 drain in order, refill continues at pc 4, no gap beyond 2 cycles.
//  3 Queue holds pcs 5,6,7 and redirect_en=1, target=37: count=0 next cycle, no rom_en in
//    the redirect cycle; next valid instr_pc=37 three cycles later; pcs 5..8 never appear.
//  4 Redirect to 1023 (D=10), ready=1: retired pcs 1023,0,1,2 (wrap-around).
//  5 Run to pc 381: done=1 the cycle after the pc-381 pop and stays 1. rom_en=0 and
//    instr_valid=0 thereafter. Redirect while done is ignored. Reset clears done.
//  6 Full queue with inflight=1, assert reset one cycle: next cycle count=0, instr_valid=0,
//    done=0; the following cycle rom_en=1, rom_addr=RESET_PC; stale rom_data not pushed.

Source files
------------

// File: rtl/fetch_queue.sv
// Prefetching in-order instruction queue fed by a registered-read ROM; issue in N is visible in N+2.
// Backpressure: instr_ready gates pops; issue stalls while queue occupancy plus in-flight reaches DEPTH.
module fetch_queue #(
    parameter int            D        = 10,
    parameter int            IW       = 9,
    parameter int            DEPTH    = 4,
    parameter logic [D-1:0]  RESET_PC = '0,
    parameter logic [D-1:0]  DONE_PC  = D'(381),
    localparam int           CW       = $clog2(DEPTH + 1),
    localparam int           PW       = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          reset,
    output logic          rom_en,
    output logic [D-1:0]  rom_addr,
    input  logic [IW-1:0] rom_data,
    input  logic          redirect_en,
    input  logic [D-1:0]  redirect_target,
    output logic          instr_valid,
    input  logic          instr_ready,
    output logic [IW-1:0] instr,
    output logic [D-1:0]  instr_pc,
    output logic [CW-1:0] count,
    output logic          done
);

    typedef struct packed {
        logic [IW-1:0] instr;
        logic [D-1:0]  pc;
    } entry_t;

    logic [D-1:0]  fpc_q, fpc_d;
    logic [D-1:0]  req_pc_q, req_pc_d;
    logic          inflight_q, inflight_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          done_q, done_d;
    entry_t        mem_q [DEPTH];
    entry_t        mem_d [DEPTH];

    logic issue, head_vld, redir, push, pop;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    always_comb begin
        // A redirect arriving after done has no effect; the queue stays frozen.
        redir    = redirect_en && !done_q;
        head_vld = (count_q != '0) && !done_q;
        issue    = !reset && !done_q && !redirect_en &&
                   ((int'(count_q) + int'(inflight_q)) < DEPTH);
        pop      = head_vld && instr_ready && !redir;
        push     = inflight_q && !redir && !done_q;

        fpc_d      = fpc_q;
        req_pc_d   = req_pc_q;
        inflight_d = 1'b0;
        rd_ptr_d   = rd_ptr_q;
        wr_ptr_d   = wr_ptr_q;
        count_d    = count_q;
        done_d     = done_q;
        mem_d      = mem_q;

        if (redir) begin
            fpc_d    = redirect_target;
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (issue) begin
                inflight_d = 1'b1;
                req_pc_d   = fpc_q;
                fpc_d      = fpc_q + D'(1);
            end
            if (push) begin
                mem_d[wr_ptr_q] = '{instr: rom_data, pc: req_pc_q};
                wr_ptr_d        = ptr_inc(wr_ptr_q);
            end
            if (pop) begin
                rd_ptr_d = ptr_inc(rd_ptr_q);
                if (mem_q[rd_ptr_q].pc == DONE_PC) begin
                    done_d = 1'b1;
                end
            end
            count_d = count_q + CW'(push) - CW'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            fpc_q      <= RESET_PC;
            req_pc_q   <= '0;
            inflight_q <= 1'b0;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            count_q    <= '0;
            done_q     <= 1'b0;
        end else begin
            fpc_q      <= fpc_d;
            req_pc_q   <= req_pc_d;
            inflight_q <= inflight_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            count_q    <= count_d;
            done_q     <= done_d;
        end
    end

    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    assign rom_en      = issue;
    assign rom_addr    = fpc_q;
    assign instr_valid = head_vld && !reset;
    assign instr       = mem_q[rd_ptr_q].instr;
    assign instr_pc    = mem_q[rd_ptr_q].pc;
    assign count       = count_q;
    assign done        = done_q;

endmodule

// File: tb/tb_fetch_queue.sv
// Bench for fetch_queue: directed scenarios with literal expectations plus a randomized run
// checked every cycle against a queue-based reference model.
module tb_fetch_queue;

    localparam int D     = 10;
    localparam int IW    = 9;
    localparam int DEPTH = 4;
    localparam int CW    = $clog2(DEPTH + 1);
    localparam int DONE  = 381;

    logic          clk;
    logic          reset;
    logic          rom_en;
    logic [D-1:0]  rom_addr;
    logic [IW-1:0] rom_data;
    logic          redirect_en;
    logic [D-1:0]  redirect_target;
    logic          instr_valid;
    logic          instr_ready;
    logic [IW-1:0] instr;
    logic [D-1:0]  instr_pc;
    logic [CW-1:0] count;
    logic          done;

    fetch_queue #(
        .D(D), .IW(IW), .DEPTH(DEPTH), .RESET_PC(10'd0), .DONE_PC(10'd381)
    ) dut (
        .clk(clk), .reset(reset), .rom_en(rom_en), .rom_addr(rom_addr),
        .rom_data(rom_data), .redirect_en(redirect_en),
        .redirect_target(redirect_target), .instr_valid(instr_valid),
        .instr_ready(instr_ready), .instr(instr), .instr_pc(instr_pc),
        .count(count), .done(done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [IW-1:0] rom_mem [1024];

    always @(posedge clk) begin
        if (rom_en) rom_data <= rom_mem[rom_addr];
    end

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, got, exp, $time);
        end
    endtask

    // Reference model: queue of {instr, pc}, fetch pc, one outstanding request, done flag.
    typedef struct {
        logic [IW-1:0] ins;
        int            pc;
    } ent_t;

    ent_t mq[$];
    int   m_fpc     = 0;
    bit   m_infl    = 0;
    int   m_infl_pc = 0;
    bit   m_done    = 0;

    always @(negedge clk) begin
        int n;
        bit e_issue, e_valid, nd;
        n       = mq.size();
        e_issue = !reset && !m_done && !redirect_en && (n + int'(m_infl) < DEPTH);
        e_valid = (n != 0) && !m_done;
        chk("rom_en", 32'(rom_en), 32'(e_issue));
        if (!reset) begin
            chk("instr_valid", 32'(instr_valid), 32'(e_valid));
            chk("count", 32'(count), 32'(n));
            chk("done", 32'(done), 32'(m_done));
            if (e_issue) chk("rom_addr", 32'(rom_addr), 32'(m_fpc));
            if (e_valid) begin
                chk("instr_pc", 32'(instr_pc), 32'(mq[0].pc));
                chk("instr", 32'(instr), 32'(mq[0].ins));
            end
        end

        if (reset) begin
            mq.delete();
            m_fpc  = 0;
            m_infl = 0;
            m_done = 0;
        end else if (redirect_en && !m_done) begin
            mq.delete();
            m_fpc  = int'(redirect_target);
            m_infl = 0;
        end else begin
            nd = m_done;
            if (e_valid && instr_ready) begin
                if (mq[0].pc == DONE) nd = 1;
                void'(mq.pop_front());
            end
            if (m_infl && !m_done) mq.push_back('{ins: rom_mem[m_infl_pc], pc: m_infl_pc});
            m_infl = e_issue;
            if (e_issue) begin
                m_infl_pc = m_fpc;
                m_fpc     = (m_fpc + 1) % 1024;
            end
            m_done = nd;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic redirect_to(input int tgt);
        redirect_en     = 1'b1;
        redirect_target = D'(tgt);
        tick();
        redirect_en = 1'b0;
    endtask

    initial begin
        int done_cycles;
        for (int i = 0; i < 1024; i++) rom_mem[i] = IW'($urandom);
        reset = 1'b1;
        redirect_en = 1'b0;
        redirect_target = '0;
        instr_ready = 1'b1;

        // Sequential fetch from reset with decode always ready.
        do_reset();
        @(negedge clk); chk("t1_rom_en_c1", 32'(rom_en), 1); chk("t1_addr_c1", 32'(rom_addr), 0);
        chk("t1_valid_c1", 32'(instr_valid), 0);
        tick();
        @(negedge clk); chk("t1_addr_c2", 32'(rom_addr), 1);
        tick();
        @(negedge clk); chk("t1_valid_c3", 32'(instr_valid), 1); chk("t1_pc_c3", 32'(instr_pc), 0);
        chk("t1_instr_c3", 32'(instr), 32'(rom_mem[0]));
        tick();
        @(negedge clk); chk("t1_pc_c4", 32'(instr_pc), 1);

        // Fill while stalled, then drain in order with refill behind.
        instr_ready = 1'b0;
        do_reset();
        repeat (8) tick();
        @(negedge clk); chk("t2_count_full", 32'(count), 4); chk("t2_rom_en_full", 32'(rom_en), 0);
        tick();
        instr_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("t2_drain_valid", 32'(instr_valid), 1);
            chk("t2_drain_pc", 32'(instr_pc), 32'(i));
            tick();
        end

        // Redirect flushes a populated queue.
        instr_ready = 1'b0;
        do_reset();
        repeat (5) tick();
        redirect_en = 1'b1;
        redirect_target = D'(37);
        @(negedge clk); chk("t3_rom_en_R", 32'(rom_en), 0);
        tick();
        redirect_en = 1'b0;
        instr_ready = 1'b1;
        @(negedge clk); chk("t3_count_R1", 32'(count), 0); chk("t3_addr_R1", 32'(rom_addr), 37);
        tick();
        @(negedge clk); chk("t3_valid_R2", 32'(instr_valid), 0);
        tick();
        @(negedge clk); chk("t3_pc_R3", 32'(instr_pc), 37); chk("t3_valid_R3", 32'(instr_valid), 1);
        chk("t3_instr_R3", 32'(instr), 32'(rom_mem[37]));

        // PC wrap-around.
        tick();
        redirect_to(1023);
        tick();
        tick();
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("t4_valid", 32'(instr_valid), 1);
            chk("t4_pc", 32'(instr_pc), 32'((1023 + i) % 1024));
            tick();
        end

        // Retiring DONE_PC; redirect ignored while done; reset clears.
        redirect_to(378);
        tick();
        tick();
        for (int i = 0; i < 4; i++) begin
            @(negedge clk); chk("t5_pc", 32'(instr_pc), 32'(378 + i));
            tick();
        end
        @(negedge clk); chk("t5_done", 32'(done), 1); chk("t5_valid", 32'(instr_valid), 0);
        chk("t5_rom_en", 32'(rom_en), 0);
        redirect_to(5);
        tick();
        tick();
        @(negedge clk); chk("t5_done_hold", 32'(done), 1); chk("t5_rom_en_hold", 32'(rom_en), 0);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        @(negedge clk); chk("t5_done_clr", 32'(done), 0); chk("t5_rom_en_rst", 32'(rom_en), 1);

        // Reset with a request in flight: stale ROM data is discarded.
        instr_ready = 1'b0;
        do_reset();
        repeat (4) tick();
        reset = 1'b1;
        @(negedge clk); chk("t6_count_pre", 32'(count), 3);
        tick();
        reset = 1'b0;
        @(negedge clk); chk("t6_count", 32'(count), 0); chk("t6_valid", 32'(instr_valid), 0);
        chk("t6_done", 32'(done), 0); chk("t6_rom_en", 32'(rom_en), 1); chk("t6_addr", 32'(rom_addr), 0);
        tick();
        @(negedge clk); chk("t6_count_stale", 32'(count), 0);

        // Randomized traffic against the model.
        done_cycles = 0;
        for (int c = 0; c < 4000; c++) begin
            instr_ready = ($urandom_range(0, 3) != 0);
            redirect_en = ($urandom_range(0, 15) == 0);
            redirect_target = ($urandom_range(0, 3) == 0) ? D'(370 + $urandom_range(0, 11))
                                                           : D'($urandom_range(0, 1023));
            done_cycles = done ? done_cycles + 1 : 0;
            reset = ($urandom_range(0, 299) == 0) || (done_cycles > 20);
            tick();
        end
        reset = 1'b0;
        redirect_en = 1'b0;
        @(negedge clk);
        #1;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
